// File: rtl/ca_row_writer.sv
// Snapshots a finished CA generation and streams it as W-bit words into one framebuffer row.
// Build option: define CA_ROW_WRITER_SCROLL_EN for a wrapping (scrolling) display instead of a single frame.
module ca_row_writer #(
  parameter int N      = 640,
  parameter int W      = 16,
  parameter int ROWS   = 480,
  parameter int ADDR_W = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [N-1:0]            cells,
  output logic                    ack,
  output logic                    fb_we,
  output logic [ADDR_W-1:0]       fb_addr,
  output logic [W-1:0]            fb_wdata,
  input  logic                    fb_ready,
  output logic [$clog2(ROWS)-1:0] row,
  output logic                    frame_full,
  output logic [$clog2(ROWS)-1:0] scroll_row,
  output logic [1:0]              state
);

  // Handshakes:
  //   load/ack : load is sampled only in IDLE and held by the controller until ack
  //              (a one-cycle pulse) is seen; load during WRITE/ACK is ignored.
  //   fb_we/fb_ready : a word moves on a posedge with fb_we=1 and fb_ready=1; while
  //              fb_ready=0 the address and data hold and the word index does not advance.

  localparam int WORDS = N / W;
  localparam int K_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t             st;
  state_t             st_nxt;
  logic [N-1:0]       shadow;
  logic [K_W-1:0]     k;
  logic [ADDR_W-1:0]  base;
  logic               skip_write;
  logic               last_xfer;

  assign last_xfer = fb_we && fb_ready && (k == K_W'(WORDS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st <= S_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: begin
        if (load) begin
          st_nxt = skip_write ? S_ACK : S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_xfer) begin
          st_nxt = S_ACK;
        end
      end
      S_ACK:   st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ack   = 1'b0;
    state = st;
    if (st == S_ACK) begin
      ack = 1'b1;
    end
  end

  // Write datapath: the shadow shifts down one word per transfer, so word k is always
  // in the low W bits and no wide mux is needed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow   <= '0;
      k        <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (load && !skip_write) begin
            shadow <= cells;
            k      <= '0;
          end
        end
        S_WRITE: begin
          if (!fb_we) begin
            // First WRITE cycle primes the output registers with word 0.
            fb_we    <= 1'b1;
            fb_addr  <= base + ADDR_W'(k);
            fb_wdata <= shadow[W-1:0];
            shadow   <= shadow >> W;
          end else if (fb_ready) begin
            if (k == K_W'(WORDS - 1)) begin
              fb_we <= 1'b0;
            end else begin
              k        <= k + K_W'(1);
              fb_addr  <= fb_addr + ADDR_W'(1);
              fb_wdata <= shadow[W-1:0];
              shadow   <= shadow >> W;
            end
          end
        end
        default: begin
          fb_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef CA_ROW_WRITER_SCROLL_EN
  logic wrapped;

  assign skip_write = 1'b0;
  assign frame_full = 1'b0;

  // Row pointer wraps and overwrites the oldest row; scroll_row follows once wrapped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row        <= '0;
      base       <= '0;
      wrapped    <= 1'b0;
      scroll_row <= '0;
    end else if (st == S_ACK) begin
      if (row == ROW_W'(ROWS - 1)) begin
        row        <= '0;
        base       <= '0;
        wrapped    <= 1'b1;
        scroll_row <= '0;
      end else begin
        row  <= row + ROW_W'(1);
        base <= base + ADDR_W'(WORDS);
        if (wrapped) begin
          scroll_row <= row + ROW_W'(1);
        end
      end
    end
  end
`else
  assign skip_write = frame_full;
  assign scroll_row = '0;

  // Single frame: after the last row the pointer parks and later loads are acked without writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row        <= '0;
      base       <= '0;
      frame_full <= 1'b0;
    end else if ((st == S_ACK) && !frame_full) begin
      if (row == ROW_W'(ROWS - 1)) begin
        frame_full <= 1'b1;
      end else begin
        row  <= row + ROW_W'(1);
        base <= base + ADDR_W'(WORDS);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ca_row_writer.sv
// Scoreboarded bench for ca_row_writer: directed rows, backpressure, snapshot, mid-row reset, frame end.
module tb_ca_row_writer;

  localparam int N      = 640;
  localparam int W      = 16;
  localparam int ROWS   = 480;
  localparam int ADDR_W = 15;
  localparam int WORDS  = N / W;
  localparam int ROW_W  = 9;
  localparam int E_W    = ADDR_W + W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic              clk;
  logic              reset_n;
  logic              load;
  logic [N-1:0]      cells;
  logic              ack;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [W-1:0]      fb_wdata;
  logic              fb_ready;
  logic [ROW_W-1:0]  row;
  logic              frame_full;
  logic [ROW_W-1:0]  scroll_row;
  logic [1:0]        state;

  ca_row_writer #(.N(N), .W(W), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .cells      (cells),
    .ack        (ack),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .fb_ready   (fb_ready),
    .row        (row),
    .frame_full (frame_full),
    .scroll_row (scroll_row),
    .state      (state)
  );

  logic [E_W-1:0] exp_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             xfer_cnt = 0;
  bit             bp_mode  = 0;
  int             model_row = 0;
  bit             model_full = 0;

  // Clock / reset-independent drivers
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    fb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        fb_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        fb_ready = 1'b1;
        ph = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected {addr,data} per accepted word; checks stall stability.
  initial begin
    logic              prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [W-1:0]      prev_data;
    logic [E_W-1:0]    e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (prev_stall) begin
          check("stall_we", 64'(fb_we), 64'd1);
          check("stall_addr", 64'(fb_addr), 64'(prev_addr));
          check("stall_data", 64'(fb_wdata), 64'(prev_data));
        end
        if (fb_we) check("we_only_in_write", 64'(state), 64'(ST_WRITE));
        if (ack)   check("ack_only_in_ack", 64'(state), 64'(ST_ACK));
        if (fb_we && fb_ready) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", fb_addr, fb_wdata);
          end else begin
            e = exp_q.pop_front();
            check("write", 64'({fb_addr, fb_wdata}), 64'(e));
          end
        end
        prev_stall = fb_we && !fb_ready;
        prev_addr  = fb_addr;
        prev_data  = fb_wdata;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic push_row(input logic [N-1:0] v, input int nwords);
    for (int k = 0; k < nwords; k++) begin
      exp_q.push_back({ADDR_W'(model_row * WORDS + k), v[k*W +: W]});
    end
  endtask

  // One load/ack handshake; load is released on the edge where ack is seen.
  task automatic run_row(input logic [N-1:0] v, input int exp_lat, input bit snap);
    int lat;
    if (!model_full) push_row(v, WORDS);
    @(posedge clk);
    #1;
    cells = v;
    load = 1'b1;
    @(posedge clk);
    #1;
    if (snap) cells = ~v;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (ack) break;
      if (lat > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack", lat);
        break;
      end
    end
    if (exp_lat > 0) check("ack_latency", 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    load = 1'b0;
`ifdef CA_ROW_WRITER_SCROLL_EN
    if (model_row == ROWS - 1) model_row = 0;
    else model_row++;
`else
    if (!model_full) begin
      if (model_row == ROWS - 1) model_full = 1;
      else model_row++;
    end
`endif
    @(negedge clk);
    check("row_after_ack", 64'(row), 64'(model_row));
    check("words_left", 64'(exp_q.size()), 64'd0);
    check("frame_full", 64'(frame_full), 64'(model_full));
  endtask

  initial begin
    logic [N-1:0] v;
    int c0;
    int guard;
    reset_n = 1'b0;
    load    = 1'b0;
    cells   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_fb_we", 64'(fb_we), 64'd0);
    check("rst_fb_addr", 64'(fb_addr), 64'd0);
    check("rst_fb_wdata", 64'(fb_wdata), 64'd0);
    check("rst_row", 64'(row), 64'd0);
    check("rst_frame_full", 64'(frame_full), 64'd0);
    check("rst_scroll_row", 64'(scroll_row), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Basic row: single set cell 17 -> word 1 = 16'h0002
    v = '0;
    v[17] = 1'b1;
    run_row(v, 42, 0);

    v = {40{16'hA5C3}};
    run_row(v, 42, 0);
    for (int k = 0; k < WORDS; k++) v[k*W +: W] = 16'(k * 16'h0101);
    run_row(v, 42, 0);

    // Row 3 under 1,0,0,1 backpressure
    v = {20{32'hDEADBEEF}};
    bp_mode = 1;
    run_row(v, 0, 0);
    bp_mode = 0;

    // Row 4: cells change right after capture; load held through ACK
    for (int k = 0; k < WORDS; k++) v[k*W +: W] = 16'h8000 | 16'(k * 3);
    run_row(v, 42, 1);
    repeat (5) @(negedge clk);
    check("idle_after_snapshot", 64'(state), 64'(ST_IDLE));
    check("row_after_snapshot", 64'(row), 64'd5);

    // Row 5: reset after word 10 transfers
    v = {40{16'h5A5A}};
    push_row(v, 11);
    c0 = xfer_cnt;
    @(posedge clk);
    #1;
    cells = v;
    load = 1'b1;
    guard = 0;
    forever begin
      @(posedge clk);
      guard++;
      if (xfer_cnt >= c0 + 11) break;
      if (guard > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL midrow_timeout: got %0d words, expected 11", xfer_cnt - c0);
        break;
      end
    end
    #1;
    reset_n = 1'b0;
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_fb_we", 64'(fb_we), 64'd0);
    check("midrst_ack", 64'(ack), 64'd0);
    check("midrst_row", 64'(row), 64'd0);
    check("midrst_words_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_row = 0;
    model_full = 0;
    repeat (3) @(negedge clk);
    check("midrst_no_write", 64'(xfer_cnt), 64'(c0 + 11));

    // Fill the frame: 480 rows since reset
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < WORDS; k++) v[k*W +: W] = 16'(r * 64 + k);
      if (r == ROWS - 1) check("full_before_last", 64'(frame_full), 64'd0);
      run_row(v, 42, 0);
    end
`ifdef CA_ROW_WRITER_SCROLL_EN
    check("scroll_after_wrap", 64'(scroll_row), 64'd0);
    v = {40{16'hC0DE}};
    run_row(v, 42, 0);
    check("scroll_after_481", 64'(scroll_row), 64'd1);
    check("row_after_481", 64'(row), 64'd1);
`else
    check("full_after_480", 64'(frame_full), 64'd1);
    check("row_parked", 64'(row), 64'(ROWS - 1));
    c0 = xfer_cnt;
    v = {40{16'hC0DE}};
    run_row(v, 1, 0);
    check("no_write_when_full", 64'(xfer_cnt), 64'(c0));
    check("row_parked_481", 64'(row), 64'(ROWS - 1));
    check("scroll_tied", 64'(scroll_row), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
